// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART transceiver.
// Holds the parity / FSM state encodings, the baud rate table and the
// divisor helper used to build the per-rate divisor ROM.
package uart_pkg;

  typedef enum logic [1:0] {
    PAR_NONE = 2'b00,
    PAR_EVEN = 2'b01,
    PAR_ODD  = 2'b10,
    PAR_MARK = 2'b11
  } parity_mode_t;

  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

  localparam int unsigned BAUD_TABLE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Rounded clocks per oversample tick.
  function automatic int unsigned baud_div(input int unsigned clk_freq,
                                           input logic [2:0]  idx,
                                           input int unsigned oversample);
    int unsigned den;
    den = BAUD_TABLE[idx] * oversample;
    return (clk_freq + den / 2) / den;
  endfunction

  // Parity bit that makes the frame satisfy `mode`, given the XOR of the payload.
  function automatic logic par_bit(input parity_mode_t mode, input logic ones_odd);
    case (mode)
      PAR_EVEN: return ones_odd;
      PAR_ODD:  return ~ones_odd;
      PAR_MARK: return 1'b1;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Oversample tick generator.
// Ports: clock/reset (sync, active high); baud_select picks the rate;
// idle allows the divisor to be re-registered; restart zeroes the phase
// so a new frame starts on a full-length tick; tick is a 1-cycle pulse
// every DIV clocks.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] baud_select,
  input  logic       idle,
  input  logic       restart,
  output logic       tick
);

  localparam logic [31:0] DIV_TAB [8] = '{
    baud_div(CLK_FREQ, 3'd0, OVERSAMPLE), baud_div(CLK_FREQ, 3'd1, OVERSAMPLE),
    baud_div(CLK_FREQ, 3'd2, OVERSAMPLE), baud_div(CLK_FREQ, 3'd3, OVERSAMPLE),
    baud_div(CLK_FREQ, 3'd4, OVERSAMPLE), baud_div(CLK_FREQ, 3'd5, OVERSAMPLE),
    baud_div(CLK_FREQ, 3'd6, OVERSAMPLE), baud_div(CLK_FREQ, 3'd7, OVERSAMPLE)};

  logic [31:0] div_q, cnt_q;

  // >= rather than == so a smaller divisor loaded mid-count cannot run away.
  assign tick = (cnt_q >= div_q - 32'd1);

  always_ff @(posedge clock) begin
    if (reset) begin
      div_q <= DIV_TAB[baud_select];
      cnt_q <= '0;
    end else begin
      if (idle) div_q <= DIV_TAB[baud_select];
      if (restart || tick) cnt_q <= '0;
      else                 cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/uart_param_transceiver.sv
// Full-duplex UART: parametrised width/stop bits, runtime parity,
// 16x oversampled receive with 3-sample majority and false-start reject.
// Ports: clock, reset (sync, active high); baud_select, parity_mode;
// Tx_EN/Tx_WR/Tx_DATA -> Tx_BUSY, TxD; RxD, Rx_EN -> Rx_DATA, Rx_VALID,
// Rx_PERROR, Rx_FERROR.
// Build option UART_LOOPBACK_EN adds a `loopback` input that feeds TxD
// into the receiver and parks the external TxD high.
module uart_param_transceiver
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50_000_000,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [2:0]           baud_select,
  input  logic [1:0]           parity_mode,
  input  logic                 Tx_EN,
  input  logic                 Tx_WR,
  input  logic [DATA_BITS-1:0] Tx_DATA,
  output logic                 Tx_BUSY,
  output logic                 TxD,
  input  logic                 RxD,
  input  logic                 Rx_EN,
  output logic [DATA_BITS-1:0] Rx_DATA,
  output logic                 Rx_VALID,
  output logic                 Rx_PERROR,
  output logic                 Rx_FERROR
`ifdef UART_LOOPBACK_EN
  ,
  input  logic                 loopback
`endif
);

  localparam int OS_W = $clog2(OVERSAMPLE);
  localparam logic [OS_W-1:0] OS_LAST  = OS_W'(OVERSAMPLE - 1);
  localparam logic [OS_W-1:0] OS_EARLY = OS_W'(OVERSAMPLE / 2 - 1);
  localparam logic [OS_W-1:0] OS_MID   = OS_W'(OVERSAMPLE / 2);
  localparam logic [OS_W-1:0] OS_LATE  = OS_W'(OVERSAMPLE / 2 + 1);
  localparam logic [3:0] DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0] STOP_LAST = 4'(STOP_BITS - 1);

  // ---------------- transmitter ----------------
  tx_state_t tx_state, tx_next;
  logic tx_tick, tx_start, tx_bit_end, tx_line, tx_par_bit, tx_par_en;
  logic [OS_W-1:0] tx_os;
  logic [3:0] tx_idx;
  logic [DATA_BITS-1:0] tx_sh;

  // ---------------- receiver ----------------
  rx_state_t rx_state, rx_next;
  logic rx_in, rx_s1, rx_s2, rx_prev;
  logic rx_tick, rx_start, rx_done, rx_fall, rx_bit_end, rx_smp_done, rx_maj;
  logic rx_pbit, rx_ferr;
  logic [1:0] rx_smp;
  logic [OS_W-1:0] rx_os;
  logic [3:0] rx_idx;
  logic [DATA_BITS-1:0] rx_sh;
  parity_mode_t rx_pm;

  logic both_idle;
  assign both_idle = (tx_state == TX_IDLE) && (rx_state == RX_IDLE);

  // Separate phase generators so a Tx write never shifts Rx sampling.
  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)) u_tx_baud (
    .clock(clock), .reset(reset), .baud_select(baud_select),
    .idle(both_idle), .restart(tx_start), .tick(tx_tick));

  uart_baud_gen #(.CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OVERSAMPLE)) u_rx_baud (
    .clock(clock), .reset(reset), .baud_select(baud_select),
    .idle(both_idle), .restart(rx_start), .tick(rx_tick));

`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? tx_line : RxD;
  assign TxD   = loopback ? 1'b1 : tx_line;
`else
  assign rx_in = RxD;
  assign TxD   = tx_line;
`endif

  assign Tx_BUSY    = (tx_state != TX_IDLE);
  assign tx_bit_end = tx_tick && (tx_os == OS_LAST);

  always_comb begin
    tx_next  = tx_state;
    tx_start = 1'b0;
    if (!Tx_EN) tx_next = TX_IDLE;
    else begin
      case (tx_state)
        TX_IDLE:   if (Tx_WR) begin tx_next = TX_START; tx_start = 1'b1; end
        TX_START:  if (tx_bit_end) tx_next = TX_DATA;
        TX_DATA:   if (tx_bit_end && tx_idx == DATA_LAST) tx_next = tx_par_en ? TX_PARITY : TX_STOP;
        TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
        TX_STOP:   if (tx_bit_end && tx_idx == STOP_LAST) tx_next = TX_IDLE;
        default:   tx_next = TX_IDLE;
      endcase
    end
  end

  always_comb begin
    case (tx_state)
      TX_START:  tx_line = 1'b0;
      TX_DATA:   tx_line = tx_sh[0];
      TX_PARITY: tx_line = tx_par_bit;
      default:   tx_line = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      tx_state   <= TX_IDLE;
      tx_os      <= '0;
      tx_idx     <= '0;
      tx_sh      <= '0;
      tx_par_bit <= 1'b0;
      tx_par_en  <= 1'b0;
    end else begin
      tx_state <= tx_next;
      if (tx_start) begin
        tx_os      <= '0;
        tx_idx     <= '0;
        tx_sh      <= Tx_DATA;
        tx_par_bit <= par_bit(parity_mode_t'(parity_mode), ^Tx_DATA);
        tx_par_en  <= (parity_mode_t'(parity_mode) != PAR_NONE);
      end else if (tx_tick && tx_state != TX_IDLE) begin
        tx_os <= tx_os + OS_W'(1);
        if (tx_os == OS_LAST) begin
          // idx counts bits within the current state (data or stop)
          tx_idx <= (tx_next != tx_state) ? '0 : tx_idx + 4'd1;
          if (tx_state == TX_DATA) tx_sh <= tx_sh >> 1;
        end
      end
    end
  end

  // Receive: fall detect on the synchronised line, majority of 3 mid-bit samples.
  assign rx_fall     = rx_prev & ~rx_s2;
  assign rx_bit_end  = rx_tick && (rx_os == OS_LAST);
  assign rx_smp_done = rx_tick && (rx_os == OS_LATE);
  assign rx_maj      = (rx_smp[1] & rx_smp[0]) | (rx_smp[1] & rx_s2) | (rx_smp[0] & rx_s2);

  always_comb begin
    rx_next  = rx_state;
    rx_start = 1'b0;
    rx_done  = 1'b0;
    if (!Rx_EN) rx_next = RX_IDLE;
    else begin
      case (rx_state)
        RX_IDLE:   if (rx_fall) begin rx_next = RX_START; rx_start = 1'b1; end
        RX_START:  if (rx_tick && rx_os == OS_MID && rx_s2) rx_next = RX_IDLE;  // false start
                   else if (rx_bit_end) rx_next = RX_DATA;
        RX_DATA:   if (rx_bit_end && rx_idx == DATA_LAST) rx_next = (rx_pm != PAR_NONE) ? RX_PARITY : RX_STOP;
        RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
        // Finish at mid-point of the last stop bit so a following start edge is caught.
        RX_STOP:   if (rx_smp_done && rx_idx == STOP_LAST) begin rx_next = RX_IDLE; rx_done = 1'b1; end
        default:   rx_next = RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rx_s1     <= 1'b1;
      rx_s2     <= 1'b1;
      rx_prev   <= 1'b1;
      rx_state  <= RX_IDLE;
      rx_os     <= '0;
      rx_idx    <= '0;
      rx_smp    <= '0;
      rx_sh     <= '0;
      rx_pbit   <= 1'b0;
      rx_ferr   <= 1'b0;
      rx_pm     <= PAR_NONE;
      Rx_DATA   <= '0;
      Rx_VALID  <= 1'b0;
      Rx_PERROR <= 1'b0;
      Rx_FERROR <= 1'b0;
    end else begin
      rx_s1    <= rx_in;
      rx_s2    <= rx_s1;
      rx_prev  <= rx_s2;
      rx_state <= rx_next;
      Rx_VALID <= rx_done;
      if (rx_start) begin
        rx_os   <= '0;
        rx_idx  <= '0;
        rx_ferr <= 1'b0;
        rx_pm   <= parity_mode_t'(parity_mode);
      end else if (rx_tick && rx_state != RX_IDLE) begin
        rx_os <= rx_os + OS_W'(1);
        if (rx_os == OS_EARLY) rx_smp[1] <= rx_s2;
        if (rx_os == OS_MID)   rx_smp[0] <= rx_s2;
        if (rx_os == OS_LATE) begin
          case (rx_state)
            RX_DATA:   rx_sh   <= {rx_maj, rx_sh[DATA_BITS-1:1]};
            RX_PARITY: rx_pbit <= rx_maj;
            RX_STOP:   if (!rx_maj) rx_ferr <= 1'b1;
            default:   ;
          endcase
        end
        if (rx_os == OS_LAST) rx_idx <= (rx_next != rx_state) ? '0 : rx_idx + 4'd1;
      end
      if (rx_done) begin
        Rx_DATA   <= rx_sh;
        Rx_PERROR <= (rx_pm != PAR_NONE) && (rx_pbit != par_bit(rx_pm, ^rx_sh));
        Rx_FERROR <= rx_ferr | ~rx_maj;
      end
    end
  end

endmodule

// File: tb/tb_uart_param_transceiver.sv
// Directed bench for uart_param_transceiver at 50 MHz, baud index 7
// (27 clocks/tick, 432 clocks/bit). Loopback is emulated by muxing TxD
// onto RxD in the bench.
module tb_uart_param_transceiver;
  import uart_pkg::*;

  localparam int BIT = 432;

  logic clock = 1'b0;
  logic reset;
  logic [2:0] baud_select;
  logic [1:0] parity_mode;
  logic Tx_EN, Tx_WR, Rx_EN;
  logic [7:0] Tx_DATA, Rx_DATA;
  logic Tx_BUSY, TxD, RxD, Rx_VALID, Rx_PERROR, Rx_FERROR;
  logic lb, rxd_drv;

  int checks = 0;
  int failures = 0;
  int vld_cnt = 0;
  logic [7:0] cap_d = '0;
  logic cap_pe = 1'b0, cap_fe = 1'b0;
  int busy_cnt, frame_vld, first_tick, second_tick, v0;
  logic txd_smp;

  always #5 clock = ~clock;

  assign RxD = lb ? TxD : rxd_drv;

  uart_param_transceiver u_dut (
    .clock(clock), .reset(reset), .baud_select(baud_select), .parity_mode(parity_mode),
    .Tx_EN(Tx_EN), .Tx_WR(Tx_WR), .Tx_DATA(Tx_DATA), .Tx_BUSY(Tx_BUSY), .TxD(TxD),
    .RxD(RxD), .Rx_EN(Rx_EN), .Rx_DATA(Rx_DATA), .Rx_VALID(Rx_VALID),
    .Rx_PERROR(Rx_PERROR), .Rx_FERROR(Rx_FERROR)
`ifdef UART_LOOPBACK_EN
    , .loopback(1'b0)
`endif
  );

  // Capture every receive completion.
  always @(posedge clock) begin
    if (Rx_VALID) begin
      vld_cnt <= vld_cnt + 1;
      cap_d   <= Rx_DATA;
      cap_pe  <= Rx_PERROR;
      cap_fe  <= Rx_FERROR;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Write one byte and watch n cycles; optional second write at wr2_at.
  task automatic run_tx(input logic [7:0] d, input int n, input int smp_at, input int wr2_at);
    v0 = vld_cnt;
    busy_cnt = 0;
    @(negedge clock); Tx_DATA = d; Tx_WR = 1'b1;
    @(negedge clock); Tx_WR = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (Tx_BUSY) busy_cnt++;
      if (i == smp_at) txd_smp = TxD;
      if (i == wr2_at) begin Tx_DATA = 8'h11; Tx_WR = 1'b1; end
      else Tx_WR = 1'b0;
      @(negedge clock);
    end
    frame_vld = vld_cnt - v0;
  endtask

  task automatic send_bit(input logic b);
    rxd_drv = b;
    repeat (BIT) @(negedge clock);
  endtask

  task automatic drive_rx(input logic [7:0] d, input logic has_par, input logic pbit, input logic stop);
    v0 = vld_cnt;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(d[i]);
    if (has_par) send_bit(pbit);
    send_bit(stop);
    rxd_drv = 1'b1;
    repeat (300) @(negedge clock);
    frame_vld = vld_cnt - v0;
  endtask

  initial begin
    reset = 1'b1; baud_select = 3'd7; parity_mode = 2'b00;
    Tx_EN = 1'b1; Tx_WR = 1'b0; Tx_DATA = '0; Rx_EN = 1'b1;
    rxd_drv = 1'b1; lb = 1'b0; txd_smp = 1'bx;
    repeat (2) @(posedge clock);
    @(negedge clock); reset = 1'b0;

    // reset state
    check("rst_txd", TxD, 1);
    check("rst_busy", Tx_BUSY, 0);
    check("rst_valid", Rx_VALID, 0);
    check("rst_data", Rx_DATA, 0);
    check("rst_perr", Rx_PERROR, 0);
    check("rst_ferr", Rx_FERROR, 0);

    // first tick in the 27th cycle after release, then every 27
    first_tick = -1; second_tick = -1;
    for (int i = 0; i < 80; i++) begin
      if (u_dut.u_tx_baud.tick) begin
        if (first_tick < 0) first_tick = i;
        else if (second_tick < 0) second_tick = i;
      end
      @(negedge clock);
    end
    check("first_tick", first_tick, 26);
    check("second_tick", second_tick, 53);

    // 8N1 loopback 0xA8
    lb = 1'b1;
    run_tx(8'hA8, 4400, 0, -1);
    check("n1_start_bit", txd_smp, 0);
    check("n1_busy_cycles", busy_cnt, 10 * BIT);
    check("n1_valid_cnt", frame_vld, 1);
    check("n1_data", cap_d, 8'hA8);
    check("n1_perr", cap_pe, 0);
    check("n1_ferr", cap_fe, 0);

    // parity bit of 0x88 (two ones): even -> 0, odd -> 1
    parity_mode = 2'b01;
    run_tx(8'h88, 4800, 9 * BIT + BIT / 2, -1);
    check("even_par_bit", txd_smp, 0);
    check("even_valid_cnt", frame_vld, 1);
    check("even_data", cap_d, 8'h88);
    check("even_perr", cap_pe, 0);
    parity_mode = 2'b10;
    run_tx(8'h88, 4800, 9 * BIT + BIT / 2, -1);
    check("odd_par_bit", txd_smp, 1);
    check("odd_busy_cycles", busy_cnt, 11 * BIT);
    check("odd_perr", cap_pe, 0);

    // bench-driven even frame with parity flipped
    lb = 1'b0;
    parity_mode = 2'b01;
    drive_rx(8'h88, 1'b1, 1'b1, 1'b1);
    check("perr_valid_cnt", frame_vld, 1);
    check("perr_data", cap_d, 8'h88);
    check("perr_flag", cap_pe, 1);
    check("perr_ferr", cap_fe, 0);

    // stop bit low -> framing error, held until next frame
    parity_mode = 2'b00;
    drive_rx(8'h55, 1'b0, 1'b0, 1'b0);
    check("ferr_valid_cnt", frame_vld, 1);
    check("ferr_data", cap_d, 8'h55);
    check("ferr_flag", cap_fe, 1);
    check("ferr_perr", cap_pe, 0);
    check("ferr_hold", Rx_FERROR, 1);
    drive_rx(8'hC3, 1'b0, 1'b0, 1'b1);
    check("clean_data", cap_d, 8'hC3);
    check("clean_ferr", cap_fe, 0);

    // 135-clock glitch: rejected at the mid-start sample
    v0 = vld_cnt;
    rxd_drv = 1'b0;
    repeat (135) @(negedge clock);
    rxd_drv = 1'b1;
    repeat (600) @(negedge clock);
    check("glitch_no_valid", vld_cnt - v0, 0);
    check("glitch_rx_idle", 32'(u_dut.rx_state), 32'(RX_IDLE));
    drive_rx(8'h3C, 1'b0, 1'b0, 1'b1);
    check("after_glitch_valid", frame_vld, 1);
    check("after_glitch_data", cap_d, 8'h3C);

    // write while busy is ignored
    lb = 1'b1;
    run_tx(8'h5A, 4400, -1, 1000);
    check("wr2_busy_cycles", busy_cnt, 10 * BIT);
    check("wr2_valid_cnt", frame_vld, 1);
    check("wr2_data", cap_d, 8'h5A);

    // Tx_EN dropped during data bits
    lb = 1'b0;
    @(negedge clock); Tx_DATA = 8'h00; Tx_WR = 1'b1;
    @(negedge clock); Tx_WR = 1'b0;
    repeat (1000) @(negedge clock);
    check("abort_pre_txd", TxD, 0);
    check("abort_pre_busy", Tx_BUSY, 1);
    Tx_EN = 1'b0;
    @(negedge clock);
    check("abort_txd", TxD, 1);
    check("abort_busy", Tx_BUSY, 0);
    Tx_EN = 1'b1;
    repeat (50) @(negedge clock);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_param_transceiver.md
Name: uart_param_transceiver

Overview:
Full-duplex UART transceiver; parametrised successor of the fixed 8-bit uart_communication block. Adds configurable data width, stop-bit count, runtime parity mode, 16x-oversampled receive with majority vote, and false-start rejection. Sits between the CPU-side register interface and the serial pins.

Parameters:
CLK_FREQ, 50_000_000, system clock frequency in Hz.
DATA_BITS, 8, payload width; legal range 5..9.
STOP_BITS, 1, stop bits transmitted and checked; 1 or 2.
OVERSAMPLE, 16, receive ticks per bit; fixed power of two, at least 8.

Ports:
clock  in  1  system clock.
reset  in  1  synchronous, active-high reset.
baud_select  in  3  rate index: 0=300, 1=1200, 2=4800, 3=9600, 4=19200, 5=38400, 6=57600, 7=115200.
parity_mode  in  2  00=none, 01=even, 10=odd, 11=mark (parity bit always 1).
Tx_EN  in  1  transmitter enable.
Tx_WR  in  1  single-cycle write strobe.
Tx_DATA  in  DATA_BITS  payload to send, LSB first.
Tx_BUSY  out  1  frame in progress.
TxD  out  1  serial output; idles high.
RxD  in  1  asynchronous serial input.
Rx_EN  in  1  receiver enable.
Rx_DATA  out  DATA_BITS  last received payload.
Rx_VALID  out  1  one-cycle pulse when a frame completes.
Rx_PERROR  out  1  parity error of the last frame.
Rx_FERROR  out  1  framing error of the last frame.

Behaviour:
- Reset: TxD=1; Tx_BUSY=0; Rx_DATA=0; Rx_VALID=0; Rx_PERROR=0; Rx_FERROR=0; both FSMs return to IDLE; divisor loaded from baud_select. Reset during a frame aborts it immediately.
- Baud tick: one-cycle pulse every DIV clocks. DIV = round(CLK_FREQ / (baud*OVERSAMPLE)); at 50 MHz and index 7, DIV=27.
- baud_select is re-registered only when both FSMs are in IDLE. Changes made mid-frame take effect after the frame.
- Tx FSM states: IDLE, START, DATA, PARITY, STOP.
  - Each bit lasts exactly OVERSAMPLE ticks.
  - Tx_WR with Tx_EN=1 and Tx_BUSY=0 latches Tx_DATA. Tx_BUSY rises the next cycle, and the tick phase restarts so the start bit is full length.
  - PARITY state is skipped when parity_mode=00.
  - Tx_BUSY falls the cycle after the last stop bit ends.
  - Tx_WR while busy is ignored; Tx_DATA is not re-sampled.
  - Tx_EN low mid-frame: abort; TxD=1 and Tx_BUSY=0 on the next cycle.
- Rx path: RxD passes through a 2-flop synchronizer. Rx FSM states: IDLE, START, DATA, PARITY, STOP.
  - Rx_EN low holds the FSM in IDLE.
  - A falling edge in IDLE starts a frame. At tick OVERSAMPLE/2, line high means false start: return to IDLE with no output.
  - Every bit is the majority of samples at ticks OVERSAMPLE/2-1, OVERSAMPLE/2, OVERSAMPLE/2+1.
  - Parity is checked against parity_mode.
  - With STOP_BITS=2, any stop sample low sets FERROR.
  - At the mid-point of the final stop bit, in one cycle: Rx_DATA, Rx_PERROR and Rx_FERROR are updated, and Rx_VALID pulses for 1 cycle.
  - Rx_VALID pulses even on error. Error flags hold until the next Rx_VALID.
  - The FSM returns to IDLE at that same mid-point, so back-to-back frames are accepted.
- Tx and Rx run fully independently; simultaneous activity is legal.

Optional Feature:
UART_LOOPBACK_EN.
- Defined: adds input port loopback (1 bit). When loopback=1, the receiver synchronizer takes TxD instead of RxD, and the external TxD is forced to 1.
- Undefined: no loopback port; the receiver always uses RxD.

Decomposition:
- Package uart_pkg holds:
  - parity_mode_t enum;
  - tx_state_t and rx_state_t enums;
  - the baud rate table;
  - a constant function baud_div(CLK_FREQ, index, OVERSAMPLE).
- One sub-module, uart_baud_gen, contains the divisor register, tick counter and idle-gated reload. The transmitter and receiver FSMs live in uart_param_transceiver.

Test Plan:
- Reset held 2 cycles, then released -> TxD=1, Tx_BUSY=0, Rx_VALID=0, Rx_DATA=0; no tick before DIV=27 clocks.
- baud 7, 8N1, loopback, Tx_DATA=0xA8 -> Tx_BUSY high for 4320 clocks; one Rx_VALID with Rx_DATA=0xA8, PERROR=0, FERROR=0.
- parity even then odd, Tx_DATA=0x88 -> parity bit on TxD is 0 then 1. A bench-driven RxD frame with the parity bit flipped -> Rx_VALID with Rx_PERROR=1.
- RxD frame 0x55 with stop bit driven low -> Rx_VALID, Rx_DATA=0x55, Rx_FERROR=1. The next clean frame clears Rx_FERROR.
- RxD low pulse of 5 ticks (135 clocks) -> no Rx_VALID; FSM back in IDLE; a following valid frame 0x3C is received correctly.
- Second Tx_WR (0x11) during a frame -> ignored, the first frame completes unchanged. Tx_EN dropped mid-DATA -> TxD=1 and Tx_BUSY=0 next cycle.
